serial_seq_tx: RTL and testbench
================================

SERIAL_SEQ_TX -- requirements
Module: serial_seq_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, legal range 2-16: number of bits in one serialized word.
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port load  input  1  request to start a transmission, sampled at a rising clk edge.
REQ-005 The block SHALL have port data_in  input  WIDTH  word to serialize, sent MSB first.
REQ-006 The block SHALL have port rep  input  4  number of times the word is sent, with 0 treated as 1.
REQ-007 The block SHALL have port ready  output  1  high when idle, meaning load will be accepted.
REQ-008 The block SHALL have port bit_out  output  1  serial data line.
REQ-009 The block SHALL have port bit_valid  output  1  high when bit_out carries a stream bit.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse when a transmission completes.
REQ-011 The block SHALL have port det_cnt  output  8  count of "100" occurrences in the valid bits emitted since the last accepted load.

Function
REQ-012 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output.
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and GAP.
REQ-014 In IDLE the block SHALL drive ready=1, bit_valid=0 and bit_out=0.
REQ-015 At an edge where load=1 and ready=1, the block SHALL, all at that edge:
  - capture data_in;
  - set remaining repetitions to max(rep,1);
  - clear det_cnt and the two-bit history;
  - drive ready=0, bit_valid=1, bit_out=data_in[WIDTH-1];
  - enter SHIFT.
REQ-016 At an edge where load=1 and ready=0, the block SHALL ignore load, with no change to the captured word, rep or outputs.
REQ-017 In SHIFT, each subsequent edge SHALL present the next lower bit on bit_out with bit_valid=1, so one word occupies exactly WIDTH consecutive valid cycles.
REQ-018 After the last bit of a repetition with remaining>1, the next edge SHALL enter GAP for exactly one cycle with bit_valid=0 and bit_out=0, then decrement remaining.
REQ-019 The edge after a GAP cycle SHALL re-present the captured word's MSB and return to SHIFT.
REQ-020 After the last bit of the last repetition, the next edge SHALL enter IDLE with ready=1, bit_valid=0, bit_out=0 and done=1.
REQ-021 done SHALL be 1 for exactly one cycle; at all other times it SHALL be 0.
REQ-022 A load accepted in the done cycle SHALL start a new transmission with no extra idle cycle, giving a back-to-back period of rep*(WIDTH+1) cycles.
REQ-023 The history SHALL hold the last two valid bits; GAP cycles SHALL NOT enter the history, so a "100" spanning a GAP is counted.
REQ-024 det_cnt SHALL increment by 1 at the edge after a valid cycle whose bit, together with the history, forms 1,0,0.
REQ-025 det_cnt SHALL hold its value after done until the next accepted load.
REQ-026 det_cnt SHALL be 8 bits wide; the maximum count (WIDTH=16, rep=15) is below 256, so no saturation logic is required.

Reset
REQ-027 Asserting reset SHALL, immediately and without waiting for clk, force IDLE with ready=1, bit_out=0, bit_valid=0, done=0, det_cnt=0, and clear the captured word, remaining and history.
REQ-028 Reset SHALL override load; a reset asserted mid-SHIFT or mid-GAP SHALL abort the transmission with no done pulse.
REQ-029 The first edge with reset=0 and load=1 SHALL be accepted normally.

Verification
REQ-030 The bench SHALL cover async reset: assert reset mid-SHIFT between clock edges -> outputs reach IDLE values in the same cycle, no done pulse, and the next load behaves per REQ-015.
REQ-031 The bench SHALL cover a single word: WIDTH=8, data_in=8'b10010100, rep=1 -> bit_out 1,0,0,1,0,1,0,0 over 8 valid cycles, done in cycle 9, det_cnt=2.
REQ-032 The bench SHALL cover repetition: data_in=8'hA4, rep=3 -> 8 valid, GAP, 8 valid, GAP, 8 valid, then done; ready low for 26 cycles; det_cnt=6.
REQ-033 The bench SHALL cover a cross-GAP match: data_in=8'b01000010, rep=2 -> det_cnt=3, one of the three occurrences spanning the GAP.
REQ-034 The bench SHALL cover rep=0 and busy load: rep=0 -> exactly one word is sent; load pulses during SHIFT and GAP -> ignored, with the output stream unchanged.
REQ-035 The bench SHALL cover back-to-back loads: load held high with rep=1 -> a new word starts on the edge after each done cycle, with a period of 9 cycles for WIDTH=8.

Source files
------------

// File: rtl/serial_seq_tx.sv
// Serializes a WIDTH-bit word MSB first, repeated rep times with a one-cycle gap
// between repetitions, and counts "100" patterns in the emitted valid bits.
//
// state | meaning
// IDLE  | waiting for load; ready=1, line quiet
// SHIFT | presenting one bit of the captured word per cycle
// GAP   | one quiet cycle between repetitions
module serial_seq_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic [3:0]       rep,
    output logic             ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             done,
    output logic [7:0]       det_cnt
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] word;
    logic [IDX_W-1:0] idx;
    logic [3:0]       remaining;
    logic [1:0]       hist;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            word      <= '0;
            idx       <= '0;
            remaining <= '0;
            hist      <= '0;
            det_cnt   <= '0;
            ready     <= 1'b1;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;

            // Only valid bits feed the history, so a match may straddle a GAP.
            if (bit_valid) begin
                hist <= {hist[0], bit_out};
                if ({hist, bit_out} == 3'b100) begin
                    det_cnt <= det_cnt + 8'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (load && ready) begin
                        word      <= data_in;
                        remaining <= (rep == 4'd0) ? 4'd1 : rep;
                        det_cnt   <= '0;
                        hist      <= '0;
                        ready     <= 1'b0;
                        bit_valid <= 1'b1;
                        bit_out   <= data_in[WIDTH-1];
                        idx       <= IDX_TOP;
                        state     <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (idx != '0) begin
                        idx     <= idx - 1'b1;
                        bit_out <= word[idx - 1'b1];
                    end else if (remaining > 4'd1) begin
                        remaining <= remaining - 4'd1;
                        bit_valid <= 1'b0;
                        bit_out   <= 1'b0;
                        state     <= GAP;
                    end else begin
                        ready     <= 1'b1;
                        bit_valid <= 1'b0;
                        bit_out   <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end

                GAP: begin
                    bit_valid <= 1'b1;
                    bit_out   <= word[WIDTH-1];
                    idx       <= IDX_TOP;
                    state     <= SHIFT;
                end

                default: begin
                    ready     <= 1'b1;
                    bit_valid <= 1'b0;
                    bit_out   <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_seq_tx.sv
// Directed bench for serial_seq_tx (WIDTH=8): reset, single/repeated words,
// cross-gap pattern, ignored busy loads and back-to-back loads.
module tb_serial_seq_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] data_in;
    logic [3:0] rep;
    logic       ready;
    logic       bit_out;
    logic       bit_valid;
    logic       done;
    logic [7:0] det_cnt;

    int n_checks = 0;
    int n_errors = 0;

    serial_seq_tx #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .data_in   (data_in),
        .rep       (rep),
        .ready     (ready),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .done      (done),
        .det_cnt   (det_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one transmission and check every cycle up to and including done.
    // Expected per-cycle outputs {ready,bit_valid,bit_out,done}: words of 8 bits
    // MSB first, a quiet gap cycle between repetitions, done/ready on the final cycle.
    task automatic send(input logic [7:0] d, input logic [3:0] r, input bit busy,
                        input int exp_det, input int exp_low);
        int n;
        int last;
        int j;
        int low;
        bit seen_done;
        logic [3:0] exp_v;
        n = (r == 4'd0) ? 1 : int'(r);
        last = n * 9 - 1;
        low = 0;
        seen_done = 1'b0;
        data_in = d;
        rep = r;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 200; k++) begin
            j = k % 9;
            if (k == last)  exp_v = 4'b1001;
            else if (j == 8) exp_v = 4'b0000;
            else            exp_v = {1'b0, 1'b1, d[7-j], 1'b0};
            chk($sformatf("cyc%0d", k), {ready, bit_valid, bit_out, done}, exp_v);
            if (!ready) low++;
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (busy && (k == 3 || k == 8)) begin
                load = 1'b1;
                data_in = ~d;
                rep = 4'd5;
            end else begin
                load = 1'b0;
            end
            tick();
        end
        load = 1'b0;
        chk("done_seen", seen_done, 1);
        chk("det_cnt", det_cnt, exp_det);
        chk("ready_low", low, exp_low);
        tick();
        chk("done_width", done, 0);
        chk("det_hold", det_cnt, exp_det);
        chk("idle", {ready, bit_valid, bit_out}, 3'b100);
    endtask

    initial begin
        reset = 1'b1;
        load = 1'b0;
        data_in = '0;
        rep = '0;
        #12;
        chk("rst_outs", {ready, bit_valid, bit_out, done}, 4'b1000);
        chk("rst_det", det_cnt, 0);
        // load while in reset must not be accepted
        load = 1'b1;
        tick();
        chk("rst_over_load", {ready, bit_valid}, 2'b10);
        load = 1'b0;
        reset = 1'b0;
        tick();

        // async reset mid-SHIFT
        data_in = 8'b10010100;
        rep = 4'd1;
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();
        chk("pre_rst_det", det_cnt, 1);
        chk("pre_rst_busy", {ready, bit_valid}, 2'b01);
        #3;
        reset = 1'b1;
        #1;
        chk("async_outs", {ready, bit_valid, bit_out, done}, 4'b1000);
        chk("async_det", det_cnt, 0);
        tick();
        chk("async_no_done", done, 0);
        #2;
        reset = 1'b0;
        tick();
        chk("post_rst_idle", {ready, bit_valid, done}, 3'b100);

        // single word
        send(8'b10010100, 4'd1, 1'b0, 2, 8);
        // three repetitions
        send(8'hA4, 4'd3, 1'b0, 6, 26);
        // match across the gap
        send(8'b01000010, 4'd2, 1'b0, 3, 17);
        // rep=0 sends one word
        send(8'hA4, 4'd0, 1'b0, 2, 8);
        // loads during SHIFT and GAP ignored
        send(8'b01000010, 4'd2, 1'b1, 3, 17);

        // back-to-back loads held high, period 9
        data_in = 8'h96;
        rep = 4'd1;
        load = 1'b1;
        tick();
        for (int k = 0; k < 27; k++) begin
            chk($sformatf("b2b_done%0d", k), done, (k % 9 == 8) ? 1 : 0);
            chk($sformatf("b2b_valid%0d", k), bit_valid, (k % 9 == 8) ? 0 : 1);
            if (k == 8) chk("b2b_det_end", det_cnt, 1);
            if (k == 9) begin
                chk("b2b_det_clr", det_cnt, 0);
                chk("b2b_msb", {ready, bit_out}, 2'b01);
            end
            if (k == 26) load = 1'b0;
            tick();
        end
        chk("b2b_idle", {ready, bit_valid, done}, 3'b100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
